// File: rtl/jpeg_pkg.sv
// Shared JPEG back-end definitions: MCU geometry, writer FSM states and
// the layout of a buffered frame-buffer write entry.
package jpeg_pkg;

  localparam int MCU_DIM_411   = 16;
  localparam int MCU_DIM_STD   = 8;
  localparam int MCU_SHIFT_411 = $clog2(MCU_DIM_411);
  localparam int MCU_SHIFT_STD = $clog2(MCU_DIM_STD);

  localparam int RGB_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // A FIFO entry is {address, rgb}; its width follows the address width.
  function automatic int pix_entry_width(input int addr_w);
    return addr_w + RGB_W;
  endfunction

endpackage

// File: rtl/jpeg_sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count.
// A push while full is only taken if a pop frees the slot in the same cycle.
module jpeg_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/jpeg_mcu_raster_writer.sv
// Turns the decoder's MCU-ordered pixel stream into clipped, raster-linear
// frame-buffer writes through a two-stage pipeline and an output FIFO.
module jpeg_mcu_raster_writer
  import jpeg_pkg::*;
#(
  parameter int FB_W          = 640,
  parameter int FB_H          = 480,
  parameter int FB_ADDR_WIDTH = 19,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_en,
  input  logic                     cfg_411,
  input  logic [15:0]              cfg_width,
  input  logic [15:0]              cfg_height,
  input  logic [12:0]              cfg_mcu_w,
  input  logic [12:0]              cfg_mcu_h,
  input  logic                     pix_we,
  input  logic                     pix_begin,
  input  logic                     pix_end,
  input  logic [7:0]               pix_adr,
  input  logic [12:0]              pix_x_mcu,
  input  logic [12:0]              pix_y_mcu,
  input  logic [7:0]               pix_r,
  input  logic [7:0]               pix_g,
  input  logic [7:0]               pix_b,
  output logic                     pix_next,
  output logic                     fb_wr_en,
  input  logic                     fb_wr_ready,
  output logic [FB_ADDR_WIDTH-1:0] fb_wr_addr,
  output logic [23:0]              fb_wr_data,
  output logic                     busy,
  output logic                     frame_done,
  output logic [19:0]              wr_count,
  output logic [19:0]              clip_count,
  output logic                     overflow_err
);

  localparam int          ENTRY_W = pix_entry_width(FB_ADDR_WIDTH);
  localparam int          CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [16:0] FB_W17  = 17'(FB_W);
  localparam logic [16:0] FB_H17  = 17'(FB_H);
  localparam logic [19:0] CNT_MAX = '1;

  wr_state_e state, state_next;

  logic        cfg_411_q;
  logic [15:0] cfg_width_q;
  logic [15:0] cfg_height_q;
  logic [12:0] cfg_mcu_w_q;
  logic [12:0] cfg_mcu_h_q;

  logic        accept;
  logic        frame_start;
  logic        frame_last;
  logic        drained;
  logic [16:0] px_calc;
  logic [16:0] py_calc;
  logic [16:0] lim_w;
  logic [16:0] lim_h;

  logic                     s1_valid;
  logic [16:0]              s1_px;
  logic [16:0]              s1_py;
  rgb_t                     s1_rgb;
  logic                     s1_clip;
  logic [FB_ADDR_WIDTH-1:0] s1_addr;

  logic                     s2_valid;
  logic [FB_ADDR_WIDTH-1:0] s2_addr;
  rgb_t                     s2_rgb;

  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_rd_data;
  logic               pix_next_d;

  assign accept      = pix_we && pix_next;
  assign frame_start = accept && pix_begin && (pix_x_mcu == '0) && (pix_y_mcu == '0);
  assign frame_last  = accept && pix_end &&
                       (pix_x_mcu == cfg_mcu_w_q - 13'd1) &&
                       (pix_y_mcu == cfg_mcu_h_q - 13'd1);
  assign drained     = !s1_valid && !s2_valid && fifo_empty;
  assign fifo_pop    = !fifo_empty && fb_wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_411_q    <= 1'b0;
      cfg_width_q  <= '0;
      cfg_height_q <= '0;
      cfg_mcu_w_q  <= '0;
      cfg_mcu_h_q  <= '0;
    end else if (cfg_en && state == ST_IDLE) begin
      cfg_411_q    <= cfg_411;
      cfg_width_q  <= cfg_width;
      cfg_height_q <= cfg_height;
      cfg_mcu_w_q  <= cfg_mcu_w;
      cfg_mcu_h_q  <= cfg_mcu_h;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (frame_start) state_next = ST_ACTIVE;
      ST_ACTIVE: if (frame_last)  state_next = ST_FLUSH;
      ST_FLUSH:  if (drained)     state_next = ST_IDLE;
      default:                    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != ST_IDLE);
    frame_done = (state == ST_FLUSH) && drained;
  end

  // MCU-relative index to absolute pixel position; shifts keep the full 17 bits.
  always_comb begin
    if (cfg_411_q) begin
      px_calc = (17'(pix_x_mcu) << MCU_SHIFT_411) | 17'(pix_adr[3:0]);
      py_calc = (17'(pix_y_mcu) << MCU_SHIFT_411) | 17'(pix_adr[7:4]);
    end else begin
      px_calc = (17'(pix_x_mcu) << MCU_SHIFT_STD) | 17'(pix_adr[2:0]);
      py_calc = (17'(pix_y_mcu) << MCU_SHIFT_STD) | 17'(pix_adr[5:3]);
    end
  end

  always_comb begin
    lim_w   = (17'(cfg_width_q)  < FB_W17) ? 17'(cfg_width_q)  : FB_W17;
    lim_h   = (17'(cfg_height_q) < FB_H17) ? 17'(cfg_height_q) : FB_H17;
    s1_clip = (s1_px >= lim_w) || (s1_py >= lim_h);
    s1_addr = FB_ADDR_WIDTH'(s1_py) * FB_ADDR_WIDTH'(FB_W) + FB_ADDR_WIDTH'(s1_px);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_px    <= '0;
      s1_py    <= '0;
      s1_rgb   <= '0;
      s2_valid <= 1'b0;
      s2_addr  <= '0;
      s2_rgb   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_px  <= px_calc;
        s1_py  <= py_calc;
        s1_rgb <= '{r: pix_r, g: pix_g, b: pix_b};
      end
      s2_valid <= s1_valid && !s1_clip;
      if (s1_valid && !s1_clip) begin
        s2_addr <= s1_addr;
        s2_rgb  <= s1_rgb;
      end
    end
  end

  jpeg_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (s2_valid),
    .wr_data ({s2_addr, s2_rgb}),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign fb_wr_en   = !fifo_empty;
  assign fb_wr_addr = fifo_empty ? '0 : fifo_rd_data[ENTRY_W-1 -: FB_ADDR_WIDTH];
  assign fb_wr_data = fifo_empty ? '0 : fifo_rd_data[RGB_W-1:0];

  // Keep four slots of headroom: one for the registered-ready lag, two in the pipeline, one arriving now.
  assign pix_next_d = (32'(fifo_count) + 32'(s1_valid) + 32'(s2_valid) + 32'd4) <= 32'(FIFO_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_next     <= 1'b0;
      wr_count     <= '0;
      clip_count   <= '0;
      overflow_err <= 1'b0;
    end else begin
      pix_next <= pix_next_d;
      if (frame_start)                      wr_count <= '0;
      else if (fifo_pop && wr_count != CNT_MAX) wr_count <= wr_count + 20'd1;
      if (frame_start)                      clip_count <= '0;
      else if (s1_valid && s1_clip && clip_count != CNT_MAX) clip_count <= clip_count + 20'd1;
      if (s2_valid && fifo_full && !fifo_pop) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jpeg_mcu_raster_writer.sv
// Directed self-checking bench for the MCU-to-raster frame-buffer writer.
module tb_jpeg_mcu_raster_writer;

  logic        clk;
  logic        rst_n;
  logic        cfg_en;
  logic        cfg_411;
  logic [15:0] cfg_width;
  logic [15:0] cfg_height;
  logic [12:0] cfg_mcu_w;
  logic [12:0] cfg_mcu_h;
  logic        pix_we;
  logic        pix_begin;
  logic        pix_end;
  logic [7:0]  pix_adr;
  logic [12:0] pix_x_mcu;
  logic [12:0] pix_y_mcu;
  logic [7:0]  pix_r;
  logic [7:0]  pix_g;
  logic [7:0]  pix_b;
  logic        pix_next;
  logic        fb_wr_en;
  logic        fb_wr_ready;
  logic [18:0] fb_wr_addr;
  logic [23:0] fb_wr_data;
  logic        busy;
  logic        frame_done;
  logic [19:0] wr_count;
  logic [19:0] clip_count;
  logic        overflow_err;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [18:0] wr_addr_q [$];
  logic [23:0] wr_data_q [$];

  jpeg_mcu_raster_writer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_en       (cfg_en),
    .cfg_411      (cfg_411),
    .cfg_width    (cfg_width),
    .cfg_height   (cfg_height),
    .cfg_mcu_w    (cfg_mcu_w),
    .cfg_mcu_h    (cfg_mcu_h),
    .pix_we       (pix_we),
    .pix_begin    (pix_begin),
    .pix_end      (pix_end),
    .pix_adr      (pix_adr),
    .pix_x_mcu    (pix_x_mcu),
    .pix_y_mcu    (pix_y_mcu),
    .pix_r        (pix_r),
    .pix_g        (pix_g),
    .pix_b        (pix_b),
    .pix_next     (pix_next),
    .fb_wr_en     (fb_wr_en),
    .fb_wr_ready  (fb_wr_ready),
    .fb_wr_addr   (fb_wr_addr),
    .fb_wr_data   (fb_wr_data),
    .busy         (busy),
    .frame_done   (frame_done),
    .wr_count     (wr_count),
    .clip_count   (clip_count),
    .overflow_err (overflow_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Records every completed frame-buffer write and frame_done pulse.
  always @(negedge clk) begin
    if (rst_n && fb_wr_en && fb_wr_ready) begin
      wr_addr_q.push_back(fb_wr_addr);
      wr_data_q.push_back(fb_wr_data);
    end
    if (frame_done) done_cnt++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [23:0] pat(input int k);
    logic [7:0] v;
    v = k[7:0];
    return {v, ~v, v ^ 8'h5A};
  endfunction

  task automatic configure(input logic is411, input logic [15:0] w, input logic [15:0] h,
                           input logic [12:0] mw, input logic [12:0] mh);
    cfg_411    = is411;
    cfg_width  = w;
    cfg_height = h;
    cfg_mcu_w  = mw;
    cfg_mcu_h  = mh;
    cfg_en     = 1'b1;
    @(posedge clk); #1;
    cfg_en     = 1'b0;
  endtask

  // Presents one pixel and returns just after the edge that accepted it.
  task automatic applyStimulus(input logic [12:0] x, input logic [12:0] y, input logic [7:0] adr,
                               input logic first, input logic last, input logic [23:0] rgb);
    int n;
    n = 0;
    pix_we    = 1'b1;
    pix_x_mcu = x;
    pix_y_mcu = y;
    pix_adr   = adr;
    pix_begin = first;
    pix_end   = last;
    {pix_r, pix_g, pix_b} = rgb;
    @(negedge clk);
    while (!pix_next && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!pix_next) checkOutput("accept_timeout", 32'(pix_next), 32'd1);
    @(posedge clk); #1;
    pix_we    = 1'b0;
    pix_begin = 1'b0;
    pix_end   = 1'b0;
  endtask

  task automatic waitWrites(input string tag, input int target);
    int n;
    n = 0;
    while (wr_addr_q.size() < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    checkOutput(tag, 32'(wr_addr_q.size()), 32'(target));
  endtask

  initial begin
    int base;
    int accepted;
    int errs;
    int stab_errs;
    int idx;
    int done_base;
    int px, py;
    logic [18:0] exp_addr_q [$];
    logic [23:0] exp_data_q [$];

    rst_n = 1'b0; cfg_en = 1'b0; cfg_411 = 1'b0; cfg_width = '0; cfg_height = '0;
    cfg_mcu_w = '0; cfg_mcu_h = '0; pix_we = 1'b0; pix_begin = 1'b0; pix_end = 1'b0;
    pix_adr = '0; pix_x_mcu = '0; pix_y_mcu = '0; pix_r = '0; pix_g = '0; pix_b = '0;
    fb_wr_ready = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_pix_next", 32'(pix_next), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_wr_count", 32'(wr_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // T1: async reset mid-frame with five entries waiting in the FIFO
    configure(1'b1, 16'd32, 16'd16, 13'd2, 13'd1);
    for (int i = 0; i < 5; i++) applyStimulus(13'd0, 13'd0, 8'(i), i == 0, 1'b0, pat(i));
    repeat (4) @(negedge clk);
    checkOutput("t1_pre_wr_en", 32'(fb_wr_en), 32'd1);
    checkOutput("t1_pre_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t1_rst_wr_en", 32'(fb_wr_en), 32'd0);
    checkOutput("t1_rst_busy", 32'(busy), 32'd0);
    checkOutput("t1_rst_pix_next", 32'(pix_next), 32'd0);
    checkOutput("t1_rst_addr", 32'(fb_wr_addr), 32'd0);
    checkOutput("t1_rst_data", 32'(fb_wr_data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("t1_post_wr_en", 32'(fb_wr_en), 32'd0);
    checkOutput("t1_post_pix_next", 32'(pix_next), 32'd1);
    @(posedge clk); #1;

    // T2: 4:1:1 mapping and three-cycle latency
    base = wr_addr_q.size();
    fb_wr_ready = 1'b1;
    configure(1'b1, 16'd32, 16'd16, 13'd2, 13'd1);
    applyStimulus(13'd1, 13'd0, 8'h23, 1'b0, 1'b0, 24'h112233);
    @(negedge clk);
    checkOutput("t2_lat1_wr_en", 32'(fb_wr_en), 32'd0);
    @(negedge clk);
    checkOutput("t2_lat2_wr_en", 32'(fb_wr_en), 32'd0);
    @(negedge clk);
    checkOutput("t2_lat3_wr_en", 32'(fb_wr_en), 32'd1);
    waitWrites("t2_writes", base + 1);
    checkOutput("t2_addr", 32'(wr_addr_q[base]), 32'd1299);
    checkOutput("t2_data", 32'(wr_data_q[base]), 32'h112233);
    checkOutput("t2_wr_count", 32'(wr_count), 32'd1);
    checkOutput("t2_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // T3: 8x8 mapping; the upper two index bits must be ignored
    base = wr_addr_q.size();
    configure(1'b0, 16'd640, 16'd480, 13'd80, 13'd60);
    applyStimulus(13'd2, 13'd1, 8'h3F, 1'b0, 1'b0, 24'hA0B0C0);
    applyStimulus(13'd2, 13'd1, 8'hFF, 1'b0, 1'b0, 24'h010203);
    waitWrites("t3_writes", base + 2);
    checkOutput("t3_addr0", 32'(wr_addr_q[base]), 32'd9623);
    checkOutput("t3_data0", 32'(wr_data_q[base]), 32'hA0B0C0);
    checkOutput("t3_addr1", 32'(wr_addr_q[base+1]), 32'd9623);
    checkOutput("t3_data1", 32'(wr_data_q[base+1]), 32'h010203);
    @(posedge clk); #1;

    // T4: width clipping at 20 pixels
    base = wr_addr_q.size();
    configure(1'b1, 16'd20, 16'd16, 13'd2, 13'd1);
    applyStimulus(13'd1, 13'd0, 8'h0F, 1'b0, 1'b0, 24'hDEADBE);
    applyStimulus(13'd1, 13'd0, 8'h03, 1'b0, 1'b0, 24'h445566);
    waitWrites("t4_writes", base + 1);
    checkOutput("t4_addr", 32'(wr_addr_q[base]), 32'd19);
    checkOutput("t4_data", 32'(wr_data_q[base]), 32'h445566);
    checkOutput("t4_clip_count", 32'(clip_count), 32'd1);
    checkOutput("t4_wr_count", 32'(wr_count), 32'd4);
    @(posedge clk); #1;

    // T5: sink stalled for 50 cycles under continuous pixel offer
    base = wr_addr_q.size();
    configure(1'b1, 16'd32, 16'd16, 13'd2, 13'd1);
    fb_wr_ready = 1'b0;
    accepted = 0;
    stab_errs = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      pix_we = 1'b1; pix_x_mcu = '0; pix_y_mcu = '0;
      pix_adr = 8'(accepted);
      {pix_r, pix_g, pix_b} = pat(accepted);
      @(negedge clk);
      if (fb_wr_en && (fb_wr_addr !== 19'd0 || fb_wr_data !== pat(0))) stab_errs++;
      if (pix_next) accepted++;
      @(posedge clk); #1;
    end
    pix_we = 1'b0;
    @(negedge clk);
    checkOutput("t5_accepted", 32'(accepted), 32'd6);
    checkOutput("t5_pix_next_low", 32'(pix_next), 32'd0);
    checkOutput("t5_overflow", 32'(overflow_err), 32'd0);
    checkOutput("t5_stall_stable", 32'(stab_errs), 32'd0);
    checkOutput("t5_stall_addr", 32'(fb_wr_addr), 32'd0);
    @(posedge clk); #1;
    fb_wr_ready = 1'b1;
    waitWrites("t5_writes", base + accepted);
    errs = 0;
    for (int k = 0; k < accepted; k++) begin
      if (wr_addr_q[base+k] !== 19'((k >> 4) * 640 + (k & 15))) errs++;
      if (wr_data_q[base+k] !== pat(k)) errs++;
    end
    checkOutput("t5_order", 32'(errs), 32'd0);
    checkOutput("t5_wr_count", 32'(wr_count), 32'd10);
    @(posedge clk); #1;

    // T6: full 40x24 frame in 3x2 MCUs, with a stray cfg_en mid-frame
    base = wr_addr_q.size();
    done_base = done_cnt;
    configure(1'b1, 16'd40, 16'd24, 13'd3, 13'd2);
    idx = 0;
    for (int my = 0; my < 2; my++) begin
      for (int mx = 0; mx < 3; mx++) begin
        for (int a = 0; a < 256; a++) begin
          px = mx * 16 + (a & 15);
          py = my * 16 + (a >> 4);
          if (px < 40 && py < 24) begin
            exp_addr_q.push_back(19'(py * 640 + px));
            exp_data_q.push_back(pat(idx));
          end
          if (idx == 100) begin
            cfg_en = 1'b1;
            cfg_width = 16'd8;
          end
          applyStimulus(13'(mx), 13'(my), 8'(a), a == 0, a == 255, pat(idx));
          cfg_en = 1'b0;
          if (idx == 0) checkOutput("t6_busy_start", 32'(busy), 32'd1);
          idx++;
        end
      end
    end
    begin
      int n;
      n = 0;
      while (busy && n < 500) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (5) @(negedge clk);
    checkOutput("t6_writes", 32'(wr_addr_q.size() - base), 32'd960);
    errs = 0;
    for (int k = 0; k < exp_addr_q.size() && base + k < wr_addr_q.size(); k++) begin
      if (wr_addr_q[base+k] !== exp_addr_q[k]) errs++;
      if (wr_data_q[base+k] !== exp_data_q[k]) errs++;
    end
    checkOutput("t6_content", 32'(errs), 32'd0);
    checkOutput("t6_wr_count", 32'(wr_count), 32'd960);
    checkOutput("t6_clip_count", 32'(clip_count), 32'd576);
    checkOutput("t6_frame_done", 32'(done_cnt - done_base), 32'd1);
    checkOutput("t6_busy_end", 32'(busy), 32'd0);
    checkOutput("t6_overflow", 32'(overflow_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
